// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT slow-channel decoder.
package sent_pkg;

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  localparam logic [4:0] ENH_FRAMES    = 5'd18;
  localparam logic [4:0] SER_FRAMES    = 5'd16;
  localparam logic [4:0] ENH_ZERO_FIRST = 5'd7;
  localparam logic [4:0] ENH_ZERO_MID  = 5'd13;
  localparam logic [4:0] ENH_ZERO_END  = 5'd18;
  localparam logic [4:0] SER_CRC_LAST  = 5'd12;
  localparam logic [2:0] ONES_SAT      = 3'd6;

  // x^6+x^4+x^3+1 and x^4+x^3+x^2+1, leading term implicit
  localparam logic [5:0] ENH_CRC_POLY     = 6'h19;
  localparam logic [3:0] SER_CRC_POLY     = 4'hD;
  localparam logic [5:0] DEF_ENH_CRC_SEED = 6'h15;
  localparam logic [3:0] DEF_SER_CRC_SEED = 4'h5;

endpackage

// File: rtl/sent_serial_crc.sv
// One MSB-first bit-serial CRC update step, purely combinational.
module sent_serial_crc #(
  parameter int              WIDTH = 6,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc_out
);

  logic fb;

  assign fb      = crc_in[WIDTH-1] ^ bit_in;
  assign crc_out = {crc_in[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/sent_slow_channel_decoder.sv
// Assembles SENT short / enhanced serial messages from per-frame status nibbles,
// checks the slow-channel CRC and publishes the last good ID / data / config.
module sent_slow_channel_decoder
  import sent_pkg::*;
#(
  parameter logic [5:0] ENH_CRC_SEED = DEF_ENH_CRC_SEED,
  parameter logic [3:0] SER_CRC_SEED = DEF_SER_CRC_SEED
) (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        channel_format,
  input  logic        frame_valid,
  input  logic        frame_crc_ok,
  input  logic [3:0]  status_nibble,
  output logic [7:0]  id_received,
  output logic [15:0] data_received,
  output logic        config_received,
  output logic        msg_valid,
  output logic        msg_crc_err,
  output logic        sync_lost
);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d, idx_inc;
  logic [2:0]  ones_q, ones_d;
  logic [5:0]  hist_q, hist_d;
  logic [14:0] b2_sr_q, b2_sr_d;
  logic [10:0] b3_sr_q, b3_sr_d;
  logic [5:0]  crc_enh_q, crc_enh_d, enh_base, enh_mid, enh_next;
  logic [3:0]  crc_ser_q, crc_ser_d, ser_base, ser_next;
  logic        fmt_q;
  logic [7:0]  id_d;
  logic [15:0] data_d;
  logic        cfg_d, valid_d, crc_err_d, lost_d, restart;
  logic        b3, b2;
  logic [11:0] enh_b2_full, enh_b3_full;
  logic [15:0] ser_full;
  logic        unused_bits;

  assign b3          = status_nibble[3];
  assign b2          = status_nibble[2];
  assign idx_inc     = idx_q + 5'd1;
  assign enh_b2_full = {b2_sr_q[10:0], b2};
  assign enh_b3_full = {b3_sr_q, b3};
  assign ser_full    = {b2_sr_q, b2};
  assign unused_bits = &{1'b0, status_nibble[1:0], enh_b3_full[11], enh_b3_full[5], enh_b3_full[0]};

  // Enhanced CRC absorbs two bits per frame: b2 first, then b3.
  assign enh_base = (state_q == COLLECT) ? crc_enh_q : ENH_CRC_SEED;
  assign ser_base = b3 ? SER_CRC_SEED : crc_ser_q;

  sent_serial_crc #(.WIDTH(6), .POLY(ENH_CRC_POLY)) u_enh_b2 (
    .crc_in(enh_base), .bit_in(b2), .crc_out(enh_mid));
  sent_serial_crc #(.WIDTH(6), .POLY(ENH_CRC_POLY)) u_enh_b3 (
    .crc_in(enh_mid), .bit_in(b3), .crc_out(enh_next));
  sent_serial_crc #(.WIDTH(4), .POLY(SER_CRC_POLY)) u_ser (
    .crc_in(ser_base), .bit_in(b2), .crc_out(ser_next));

  always_ff @(posedge clk_rx or negedge reset_rx) begin
    if (!reset_rx) begin
      state_q         <= HUNT;
      idx_q           <= '0;
      ones_q          <= '0;
      hist_q          <= '0;
      b2_sr_q         <= '0;
      b3_sr_q         <= '0;
      crc_enh_q       <= '0;
      crc_ser_q       <= '0;
      fmt_q           <= 1'b0;
      id_received     <= '0;
      data_received   <= '0;
      config_received <= 1'b0;
      msg_valid       <= 1'b0;
      msg_crc_err     <= 1'b0;
      sync_lost       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ones_q          <= ones_d;
      hist_q          <= hist_d;
      b2_sr_q         <= b2_sr_d;
      b3_sr_q         <= b3_sr_d;
      crc_enh_q       <= crc_enh_d;
      crc_ser_q       <= crc_ser_d;
      fmt_q           <= channel_format;
      id_received     <= id_d;
      data_received   <= data_d;
      config_received <= cfg_d;
      msg_valid       <= valid_d;
      msg_crc_err     <= crc_err_d;
      sync_lost       <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ones_d    = ones_q;
    hist_d    = hist_q;
    b2_sr_d   = b2_sr_q;
    b3_sr_d   = b3_sr_q;
    crc_enh_d = crc_enh_q;
    crc_ser_d = crc_ser_q;
    id_d      = id_received;
    data_d    = data_received;
    cfg_d     = config_received;
    valid_d   = 1'b0;
    crc_err_d = 1'b0;
    lost_d    = 1'b0;
    restart   = 1'b0;

    if (channel_format != fmt_q) begin
      restart = 1'b1;
      lost_d  = (state_q == COLLECT);
    end else if (frame_valid && !frame_crc_ok) begin
      restart = 1'b1;
      lost_d  = (state_q == COLLECT);
    end else if (frame_valid && channel_format) begin
      if (state_q == HUNT) begin
        if (b3) begin
          ones_d = (ones_q == ONES_SAT) ? ONES_SAT : ones_q + 3'd1;
          hist_d = {hist_q[4:0], b2};
        end else if (ones_q == ONES_SAT) begin
          state_d   = COLLECT;
          idx_d     = ENH_ZERO_FIRST;
          ones_d    = '0;
          crc_enh_d = enh_next;
          b2_sr_d   = {14'b0, b2};
          b3_sr_d   = {10'b0, b3};
        end else begin
          ones_d = '0;
          hist_d = {hist_q[4:0], b2};
        end
      end else if (b3 && (idx_inc == ENH_ZERO_MID || idx_inc == ENH_ZERO_END)) begin
        // A one in a zero slot may be the start of the next preamble.
        state_d = HUNT;
        idx_d   = '0;
        ones_d  = 3'd1;
        hist_d  = {5'b0, b2};
        lost_d  = 1'b1;
      end else begin
        idx_d     = idx_inc;
        crc_enh_d = enh_next;
        b2_sr_d   = {b2_sr_q[13:0], b2};
        b3_sr_d   = {b3_sr_q[9:0], b3};
        if (idx_inc == ENH_FRAMES) begin
          state_d = HUNT;
          idx_d   = '0;
          ones_d  = '0;
          if (enh_next == hist_q) begin
            valid_d = 1'b1;
            cfg_d   = enh_b3_full[10];
            if (enh_b3_full[10]) begin
              id_d   = {4'h0, enh_b3_full[9:6]};
              data_d = {enh_b3_full[4:1], enh_b2_full};
            end else begin
              id_d   = {enh_b3_full[9:6], enh_b3_full[4:1]};
              data_d = {4'h0, enh_b2_full};
            end
          end else begin
            crc_err_d = 1'b1;
          end
        end
      end
    end else if (frame_valid) begin
      if (b3) begin
        // Frame-1 marker: start (or restart) a short message with this frame.
        state_d   = COLLECT;
        idx_d     = 5'd1;
        b2_sr_d   = {14'b0, b2};
        crc_ser_d = ser_next;
        lost_d    = (state_q == COLLECT);
      end else if (state_q == COLLECT) begin
        idx_d   = idx_inc;
        b2_sr_d = {b2_sr_q[13:0], b2};
        if (idx_inc <= SER_CRC_LAST)
          crc_ser_d = ser_next;
        if (idx_inc == SER_FRAMES) begin
          state_d = HUNT;
          idx_d   = '0;
          if (crc_ser_q == ser_full[3:0]) begin
            valid_d = 1'b1;
            id_d    = {4'h0, ser_full[15:12]};
            data_d  = {8'h00, ser_full[11:4]};
            cfg_d   = 1'b0;
          end else begin
            crc_err_d = 1'b1;
          end
        end
      end
    end

    if (restart) begin
      state_d   = HUNT;
      idx_d     = '0;
      ones_d    = '0;
      hist_d    = '0;
      b2_sr_d   = '0;
      b3_sr_d   = '0;
      crc_enh_d = '0;
      crc_ser_d = '0;
    end
  end

endmodule

// File: tb/tb_sent_slow_channel_decoder.sv
// Randomized self-checking bench: messages are built from ID/DATA/C with a
// bench-side CRC, and expectations are tracked at message level.
module tb_sent_slow_channel_decoder;

  logic        clk_rx = 1'b0;
  logic        reset_rx = 1'b0;
  logic        channel_format = 1'b1;
  logic        frame_valid = 1'b0;
  logic        frame_crc_ok = 1'b0;
  logic [3:0]  status_nibble = 4'h0;
  logic [7:0]  id_received;
  logic [15:0] data_received;
  logic        config_received;
  logic        msg_valid, msg_crc_err, sync_lost;

  sent_slow_channel_decoder dut (
    .clk_rx(clk_rx), .reset_rx(reset_rx), .channel_format(channel_format),
    .frame_valid(frame_valid), .frame_crc_ok(frame_crc_ok), .status_nibble(status_nibble),
    .id_received(id_received), .data_received(data_received),
    .config_received(config_received), .msg_valid(msg_valid),
    .msg_crc_err(msg_crc_err), .sync_lost(sync_lost));

  always #5 clk_rx = ~clk_rx;

  int n_cmp = 0, n_bad = 0;
  int cnt_v = 0, cnt_e = 0, cnt_l = 0, excl_viol = 0;
  int exp_v = 0, exp_e = 0, exp_l = 0;
  logic [7:0]  exp_id = '0;
  logic [15:0] exp_data = '0;
  logic        exp_cfg = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_rx) begin
    if (msg_valid)   cnt_v <= cnt_v + 1;
    if (msg_crc_err) cnt_e <= cnt_e + 1;
    if (sync_lost)   cnt_l <= cnt_l + 1;
    if (int'(msg_valid) + int'(msg_crc_err) + int'(sync_lost) > 1) excl_viol <= excl_viol + 1;
  end

  function automatic logic [5:0] crc6_step(input logic [5:0] c, input logic b);
    logic fb;
    fb = c[5] ^ b;
    c  = c << 1;
    return fb ? (c ^ 6'h19) : c;
  endfunction

  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    c  = c << 1;
    return fb ? (c ^ 4'hD) : c;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_rx);
      frame_valid   = 1'b0;
      frame_crc_ok  = 1'($urandom);
      status_nibble = 4'($urandom);
    end
  endtask

  // Returns at the falling edge just after the DUT sampled the frame.
  task automatic send_frame(input logic b3, input logic b2, input logic ok);
    idle($urandom_range(0, 1));
    @(negedge clk_rx);
    frame_valid   = 1'b1;
    frame_crc_ok  = ok;
    status_nibble = {b3, b2, 2'($urandom)};
    @(negedge clk_rx);
    frame_valid   = 1'b0;
    frame_crc_ok  = 1'($urandom);
    status_nibble = 4'($urandom);
  endtask

  task automatic send_enh(input logic c, input logic [7:0] id, input logic [15:0] data,
                          input int extra, input int flip_k, input int bad_j,
                          input int b3err_j, input int abort_at);
    logic [18:1] b3v, b2v;
    logic [3:0]  hi, lo;
    logic [5:0]  crc;
    hi = c ? id[3:0] : id[7:4];
    lo = c ? data[15:12] : id[3:0];
    b3v = '0;
    for (int f = 1; f <= 6; f++) b3v[f] = 1'b1;
    b3v[8] = c;
    for (int i = 0; i < 4; i++) begin
      b3v[9 + i]  = hi[3 - i];
      b3v[14 + i] = lo[3 - i];
    end
    for (int i = 0; i < 12; i++) b2v[7 + i] = data[11 - i];
    crc = 6'h15;
    for (int f = 7; f <= 18; f++) begin
      crc = crc6_step(crc, b2v[f]);
      crc = crc6_step(crc, b3v[f]);
    end
    for (int f = 1; f <= 6; f++) b2v[f] = crc[6 - f];
    for (int i = 0; i < extra; i++) send_frame(1'b1, 1'($urandom), 1'b1);
    for (int f = 1; f <= 18; f++) begin
      if (f == bad_j) begin
        send_frame(b3v[f], b2v[f], 1'b0);
        if (f >= 8) exp_l++;
        return;
      end
      if (f == b3err_j) begin
        send_frame(1'b1, b2v[f], 1'b1);
        exp_l++;
        return;
      end
      send_frame(b3v[f], b2v[f] ^ (f == flip_k), 1'b1);
      if (f == abort_at) return;
    end
    check_eq("enh_done_vld", msg_valid, flip_k == 0);
    check_eq("enh_done_err", msg_crc_err, flip_k != 0);
    if (flip_k != 0) exp_e++;
    else begin
      exp_v++;
      exp_cfg  = c;
      exp_id   = c ? {4'h0, id[3:0]} : id;
      exp_data = c ? data : {4'h0, data[11:0]};
    end
  endtask

  task automatic send_ser(input logic [3:0] id, input logic [7:0] data,
                          input int flip_k, input int bad_j, input int partial);
    logic [15:0] w;
    logic [3:0]  crc;
    crc = 4'h5;
    w = {id, data, 4'h0};
    for (int i = 15; i >= 4; i--) crc = crc4_step(crc, w[i]);
    w[3:0] = crc;
    for (int f = 1; f <= partial; f++) send_frame(f == 1, 1'($urandom), 1'b1);
    for (int f = 1; f <= 16; f++) begin
      if (f == bad_j) begin
        send_frame(f == 1, w[16 - f], 1'b0);
        if (f >= 2) exp_l++;
        return;
      end
      send_frame(f == 1, w[16 - f] ^ (f == flip_k), 1'b1);
      if (f == 1 && partial > 0) begin
        check_eq("ser_restart", sync_lost, 1);
        exp_l++;
      end
    end
    check_eq("ser_done_vld", msg_valid, flip_k == 0);
    check_eq("ser_done_err", msg_crc_err, flip_k != 0);
    if (flip_k != 0) exp_e++;
    else begin
      exp_v++;
      exp_cfg  = 1'b0;
      exp_id   = {4'h0, id};
      exp_data = {8'h00, data};
    end
  endtask

  task automatic end_check(input string tag);
    idle(2);
    #1;
    check_eq({tag, "/n_vld"}, cnt_v, exp_v);
    check_eq({tag, "/n_err"}, cnt_e, exp_e);
    check_eq({tag, "/n_lost"}, cnt_l, exp_l);
    check_eq({tag, "/excl"}, excl_viol, 0);
    check_eq({tag, "/id"}, id_received, exp_id);
    check_eq({tag, "/data"}, data_received, exp_data);
    check_eq({tag, "/cfg"}, config_received, exp_cfg);
  endtask

  task automatic set_fmt(input logic v);
    if (channel_format != v) begin
      @(negedge clk_rx);
      channel_format = v;
      idle(2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_c;
    logic [7:0]  r_id;
    logic [15:0] r_d;
    int          fmt, mode, flip_k, bad_j, b3err_j, extra;

    idle(3);
    check_eq("rst/id", id_received, 0);
    check_eq("rst/data", data_received, 0);
    check_eq("rst/pulses", {msg_valid, msg_crc_err, sync_lost}, 0);
    @(negedge clk_rx);
    reset_rx = 1'b1;
    idle(3);

    send_enh(1'b0, 8'h55, 16'h0001, 0, 0, 0, 0, 0);
    end_check("enh_c0");
    send_enh(1'b1, 8'h0A, 16'hBCDE, 3, 0, 0, 0, 0);
    end_check("enh_c1_align");
    send_enh(1'b0, 8'h55, 16'h0001, 0, 3, 0, 0, 0);
    end_check("enh_crc_flip");

    set_fmt(1'b0);
    send_ser(4'h3, 8'h7E, 0, 0, 0);
    end_check("ser_basic");

    set_fmt(1'b1);
    send_enh(1'b0, 8'h55, 16'h0001, 0, 0, 10, 0, 0);
    end_check("enh_bad_frame");
    send_enh(1'b0, 8'h12, 16'h0345, 0, 0, 0, 0, 0);
    end_check("enh_after_bad");

    send_enh(1'b1, 8'h07, 16'h9ABC, 0, 0, 0, 13, 0);
    end_check("enh_zero13");
    send_enh(1'b0, 8'hC3, 16'h0F0F, 0, 0, 0, 0, 0);
    end_check("enh_after_z13");

    send_enh(1'b0, 8'h21, 16'h0777, 0, 0, 0, 0, 10);
    @(negedge clk_rx);
    channel_format = 1'b0;
    exp_l++;
    end_check("fmt_change");
    send_ser(4'hB, 8'h5A, 0, 0, 7);
    end_check("ser_restart");

    set_fmt(1'b1);
    send_enh(1'b0, 8'h66, 16'h0123, 0, 0, 0, 0, 11);
    @(negedge clk_rx);
    frame_valid   = 1'b1;
    frame_crc_ok  = 1'b1;
    status_nibble = 4'h4;
    reset_rx      = 1'b0;
    #1;
    check_eq("midrst/id", id_received, 0);
    check_eq("midrst/data", data_received, 0);
    check_eq("midrst/cfg", config_received, 0);
    check_eq("midrst/pulses", {msg_valid, msg_crc_err, sync_lost}, 0);
    exp_id = '0; exp_data = '0; exp_cfg = 1'b0;
    idle(2);
    reset_rx = 1'b1;
    idle(3);
    end_check("midrst");
    send_enh(1'b1, 8'h0E, 16'h4D2F, 1, 0, 0, 0, 0);
    end_check("after_rst");

    for (int it = 0; it < 40; it++) begin
      fmt     = $urandom_range(0, 1);
      mode    = $urandom_range(0, 5);
      r_c     = 1'($urandom);
      r_id    = 8'($urandom);
      r_d     = 16'($urandom);
      extra   = $urandom_range(0, 4);
      flip_k  = 0;
      bad_j   = 0;
      b3err_j = 0;
      set_fmt(fmt[0]);
      if (fmt == 1) begin
        if (mode == 3) flip_k = $urandom_range(1, 6);
        if (mode == 4) bad_j = $urandom_range(1, 18);
        if (mode == 5) b3err_j = ($urandom_range(0, 1) == 1) ? 13 : 18;
        send_enh(r_c, r_id, r_d, extra, flip_k, bad_j, b3err_j, 0);
      end else begin
        if (mode == 3) flip_k = $urandom_range(13, 16);
        if (mode == 4) bad_j = $urandom_range(1, 16);
        send_ser(r_id[3:0], r_d[7:0], flip_k, bad_j, (mode == 5) ? $urandom_range(1, 15) : 0);
      end
      end_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
